// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-timing derivation
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per bit, truncated (integer division).
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Half a bit period; offset from the start edge to the centre of the start bit.
    function automatic int unsigned half_bit(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, both flops reset to 1 (idle-high inputs)
// Ports: clk, rst (async, active-high), d (asynchronous input), q (synchronized output)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver, optional even parity under UART_RX_PARITY_EN
// Ports: clk, rst (async, active-high), rxd (raw serial in, idle high),
//        data (last good byte), valid (1-cycle strobe), frame_err (1-cycle strobe),
//        parity_err (1-cycle strobe, only with UART_RX_PARITY_EN), busy (frame in progress)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF  = half_bit(CLK_FREQ, BAUD);
    localparam int          CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    logic rxs;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             rxs_prev_q, rxs_prev_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            rxs_prev_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            rxs_prev_q   <= rxs_prev_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        rxs_prev_d   = rxs;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        // Line went high again before mid start bit: a glitch.
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    // Even parity: data bits plus parity bit must XOR to 0.
                    par_bad_d = ^{shift_q, rxs};
                    state_d   = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end

            BREAK: begin
                // Hold off until the line is released so a stuck-low line
                // cannot be mistaken for a stream of start bits.
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
    assign busy       = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 4_100_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int CPB  = int'(CLK_FREQ / BAUD);
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Strobe cycle after the start edge: 2 sync flops, 1 cycle to register the
    // edge, stop bit sampled at HALF + (FRAME_BITS-1) bit periods.
    localparam int LAT = 3 + HALF + (FRAME_BITS - 1) * CPB;
    localparam int TOL = 2;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;
    int overlap_cnt = 0;
    logic [7:0] exp_data;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;
    ev_t ev_q[$];

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every strobe with its cycle for later checks.
    always @(negedge clk) begin
        int n;
        ev_t e;
        n = 0;
        e.d = data;
        e.cyc = cyc;
        if (valid === 1'b1) begin e.kind = K_VALID; ev_q.push_back(e); n++; end
        if (frame_err === 1'b1) begin e.kind = K_FERR; ev_q.push_back(e); n++; end
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) begin e.kind = K_PERR; ev_q.push_back(e); n++; end
`endif
        if (n > 1) overlap_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // Reference outcome of one frame from the line-level rules.
    function automatic int exp_kind(input logic [7:0] b, input logic stop, input logic par);
        if (!stop) return K_FERR;
        if (FRAME_BITS == 11 && (^{b, par}) != 1'b0) return K_PERR;
        return K_VALID;
    endfunction

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Starts and ends on a falling clock edge; rxd is left at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (FRAME_BITS == 11) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef UART_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
`endif
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (4) @(negedge clk);
        ev_q.delete();
    endtask

    task automatic test_random_frames(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            logic stop, par;
            int k, lat, gap;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = 1'($urandom);
            k    = exp_kind(b, stop, par);
            ev_q.delete();
            send_frame(b, stop, par);
            if (k == K_VALID) exp_data = b;
            checks++;
            if (ev_q.size() != 1) begin
                errors++; $display("FAIL rand_strobe_count frame %0d got %0d want 1", i, ev_q.size());
            end else begin
                lat = ev_q[0].cyc - start_cyc;
                checks++; if (ev_q[0].kind != k) begin errors++; $display("FAIL rand_kind frame %0d byte %h got %0d want %0d", i, b, ev_q[0].kind, k); end
                checks++; if (ev_q[0].d !== exp_data) begin errors++; $display("FAIL rand_data frame %0d got %h want %h", i, ev_q[0].d, exp_data); end
                checks++; if (lat < LAT - TOL || lat > LAT + TOL) begin errors++; $display("FAIL rand_latency frame %0d got %0d want %0d", i, lat, LAT); end
            end
            rxd = 1'b1;
            gap = $urandom_range(1, CPB);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 3; i++) begin
            int g;
            g = $urandom_range(1, HALF - 4);
            ev_q.delete();
            busy_cnt = 0;
            rxd = 1'b0;
            repeat (g) @(negedge clk);
            rxd = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL glitch_strobe len %0d got %0d strobes want 0", g, ev_q.size()); end
            checks++; if (busy_cnt < HALF - 1 || busy_cnt > HALF + 2) begin errors++; $display("FAIL glitch_busy_len got %0d want %0d", busy_cnt, HALF); end
            checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_data got %h want %h", data, exp_data); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        for (int i = 2; i < 6; i++) seq[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            ev_q.delete();
            send_frame(seq[i], 1'b1, ^seq[i]);
            exp_data = seq[i];
            checks++;
            if (ev_q.size() != 1 || ev_q[0].kind != K_VALID) begin
                errors++; $display("FAIL b2b_strobe frame %0d got %0d strobes want one valid", i, ev_q.size());
            end else begin
                checks++; if (ev_q[0].d !== seq[i]) begin errors++; $display("FAIL b2b_data frame %0d got %h want %h", i, ev_q[0].d, seq[i]); end
            end
        end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        checks++; if (data !== exp_data) begin errors++; $display("FAIL b2b_final_data got %h want %h", data, exp_data); end
    endtask

    task automatic test_frame_err();
        logic [7:0] b2;
        ev_q.delete();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        checks++;
        if (ev_q.size() != 1 || ev_q[0].kind != K_FERR) begin
            errors++; $display("FAIL ferr_strobe got %0d strobes want one frame_err", ev_q.size());
        end
        checks++; if (data !== exp_data) begin errors++; $display("FAIL ferr_data got %h want %h", data, exp_data); end
        ev_q.delete();
        busy_cnt = 0;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL ferr_break_strobe got %0d want 0", ev_q.size()); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL ferr_break_busy got %0d busy cycles want 0", busy_cnt); end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        b2 = 8'($urandom_range(1, 255));
        ev_q.delete();
        send_frame(b2, 1'b1, ^b2);
        exp_data = b2;
        checks++;
        if (ev_q.size() != 1 || ev_q[0].kind != K_VALID || ev_q[0].d !== b2) begin
            errors++; $display("FAIL ferr_recover got %0d strobes data %h want one valid %h", ev_q.size(), data, b2);
        end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'($urandom);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rxd = b[4];
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        ev_q.delete();
        repeat (2) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (2 * CPB) @(negedge clk);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL midrst_stray_strobe got %0d want 0", ev_q.size()); end
        ev_q.delete();
        send_frame(8'h5A, 1'b1, ^8'h5A);
        exp_data = 8'h5A;
        checks++;
        if (ev_q.size() != 1 || ev_q[0].kind != K_VALID) begin
            errors++; $display("FAIL midrst_after_strobe got %0d strobes want one valid", ev_q.size());
        end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL midrst_after_data got %h want 5a", data); end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        ev_q.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        checks++;
        if (ev_q.size() != 1 || ev_q[0].kind != K_PERR) begin
            errors++; $display("FAIL parity_bad got %0d strobes want one parity_err", ev_q.size());
        end
        checks++; if (data !== exp_data) begin errors++; $display("FAIL parity_bad_data got %h want %h", data, exp_data); end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        ev_q.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        exp_data = 8'h07;
        checks++;
        if (ev_q.size() != 1 || ev_q[0].kind != K_VALID) begin
            errors++; $display("FAIL parity_good got %0d strobes want one valid", ev_q.size());
        end
        checks++; if (data !== 8'h07) begin errors++; $display("FAIL parity_good_data got %h want 07", data); end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        test_reset();
        test_random_frames(12);
        test_glitch();
        test_back_to_back();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_overlap got %0d cycles want 0", overlap_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
